cert_chain_responder: RTL and testbench

Responder-side engine for the USB Type-C Authentication GET_CERTIFICATE exchange. Accepts a parsed GET_CERTIFICATE request, validates it, and streams a CERTIFICATE response (header plus chain bytes read from certificate storage) or an ERROR response, one byte per cycle. Sits between the authentication message receive path and the byte-oriented transmit framer on the device side of the link.

---
 rtl/cert_chain_responder_pkg.sv | 34 +++
 rtl/cert_chain_responder_prefetch_buf.sv | 50 +++++
 rtl/cert_chain_responder.sv | 184 ++++++++++++++++++
 tb/tb_cert_chain_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cert_chain_responder_pkg.sv
// Shared constants, state encoding and request layout for the GET_CERTIFICATE responder.
package cert_chain_responder_pkg;

  localparam logic [7:0] AUTH_PROTO_VER      = 8'h01;
  localparam logic [7:0] MSG_GET_CERTIFICATE = 8'h82;
  localparam logic [7:0] MSG_CERTIFICATE     = 8'h02;
  localparam logic [7:0] MSG_ERROR           = 8'h7F;

  localparam logic [7:0] ERR_NONE            = 8'h00;
  localparam logic [7:0] ERR_INVALID_REQUEST = 8'h01;
  localparam logic [7:0] ERR_INVALID_SLOT    = 8'h02;
  localparam logic [7:0] ERR_INVALID_RANGE   = 8'h03;

  // One-hot state encoding.
  localparam logic [4:0] ST_IDLE      = 5'b00001;
  localparam logic [4:0] ST_CHECK     = 5'b00010;
  localparam logic [4:0] ST_SEND_HDR  = 5'b00100;
  localparam logic [4:0] ST_SEND_DATA = 5'b01000;
  localparam logic [4:0] ST_FINISH    = 5'b10000;

  typedef struct packed {
    logic [7:0]  version;
    logic [7:0]  msg_type;
    logic [7:0]  slot;
    logic [7:0]  param2;
    logic [15:0] offset;
    logic [15:0] length;
  } get_cert_req_t;

  function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cert_chain_responder_prefetch_buf.sv
// Two-entry prefetch FIFO for certificate bytes; gates storage reads so returning data always has room.
module cert_prefetch_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_want,
  output logic       rd_issue,
  input  logic [7:0] rd_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       head_valid
);

  logic [7:0] store [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       inflight;
  logic       pop_eff;
  logic [2:0] occ_next;

  assign head_valid = (count != 2'd0);
  assign head       = store[rd_ptr];
  assign pop_eff    = pop && head_valid;

  // Occupancy once this cycle's returning byte lands and this cycle's pop leaves;
  // a new read is allowed only if its data will find a free entry, and never while full.
  assign occ_next = {1'b0, count} + {2'b00, inflight} - {2'b00, pop_eff};
  assign rd_issue = rd_want && (count != 2'd2) && (occ_next < 3'd2);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop_eff)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop_eff};
    end
  end

  // NOTE: the data array has no reset; count/pointers decide validity, so stale bytes are never seen.
  always_ff @(posedge clk) begin
    if (inflight) store[wr_ptr] <= rd_data;
  end

endmodule

// File: rtl/cert_chain_responder.sv
// GET_CERTIFICATE responder: validates a request, then streams the CERTIFICATE or ERROR response bytewise.
module cert_chain_responder
  import cert_chain_responder_pkg::*;
#(
  parameter int SLOT_SHIFT = 10,
  parameter int ADDR_W     = 12,
  parameter int MAX_CHUNK  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_msg,
  input  logic [3:0]        slot_provisioned,
  input  logic [63:0]       slot_len_flat,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_last,
  input  logic              rsp_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N_W = $clog2(MAX_CHUNK + 1);

  get_cert_req_t req_in;
  assign req_in = get_cert_req_t'(req_msg);

  logic unused_param2;
  assign unused_param2 = ^req_in.param2;

  logic [4:0]        state;
  logic [7:0]        ver_q;
  logic [7:0]        type_q;
  logic [7:0]        slot_q;
  logic [15:0]       off_q;
  logic [15:0]       len_q;
  logic              failed;
  logic [7:0]        hdr_b1;
  logic [7:0]        hdr_b2;
  logic [1:0]        hdr_idx;
  logic [N_W-1:0]    data_left;
  logic [N_W-1:0]    rd_left;
  logic [ADDR_W-1:0] rd_addr;

  logic [1:0]        slot_idx;
  logic [15:0]       slot_len;
  logic [16:0]       avail;
  logic [16:0]       take;
  logic [N_W-1:0]    chk_n;
  logic [7:0]        chk_code;
  logic [ADDR_W-1:0] start_addr;

  assign slot_idx   = slot_q[1:0];
  assign slot_len   = slot_len_flat[16*slot_idx +: 16];
  assign avail      = {1'b0, slot_len} - {1'b0, off_q};
  assign take       = min17(min17({1'b0, len_q}, avail), 17'(MAX_CHUNK));
  assign chk_n      = N_W'(take);
  assign start_addr = ADDR_W'({slot_idx, {SLOT_SHIFT{1'b0}}}) + ADDR_W'(off_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    chk_code = ERR_NONE;
    if (ver_q != AUTH_PROTO_VER || type_q != MSG_GET_CERTIFICATE)
      chk_code = ERR_INVALID_REQUEST;
    else if (slot_q > 8'd3 || !slot_provisioned[slot_idx])
      chk_code = ERR_INVALID_SLOT;
    else if (off_q >= slot_len || len_q == 16'd0)
      chk_code = ERR_INVALID_RANGE;
  end

  logic       in_hdr;
  logic       in_data;
  logic       rd_want;
  logic       buf_pop;
  logic [7:0] buf_head;
  logic       buf_valid;

  assign in_hdr  = (state == ST_SEND_HDR);
  assign in_data = (state == ST_SEND_DATA);

  // Reads start at header byte 2 so the FIFO holds one byte plus one in flight
  // when data begins, which keeps the stream gapless without ever reading into a full buffer.
  assign rd_want = (rd_left != '0) && (in_data || (in_hdr && hdr_idx[1]));
  assign buf_pop = in_data && buf_valid && rsp_ready;

  cert_prefetch_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .rd_want    (rd_want),
    .rd_issue   (mem_rd),
    .rd_data    (mem_rdata),
    .pop        (buf_pop),
    .head       (buf_head),
    .head_valid (buf_valid)
  );

  assign mem_addr  = rd_addr;
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state == ST_CHECK) || in_hdr || in_data;
  assign done      = (state == ST_FINISH);
  assign err       = done && failed;
  assign rsp_valid = in_hdr || (in_data && buf_valid);
  assign rsp_last  = (in_hdr && hdr_idx == 2'd3 && data_left == '0) ||
                     (in_data && buf_valid && data_left == N_W'(1));

  always_comb begin
    rsp_data = 8'h00;
    if (in_hdr) begin
      case (hdr_idx)
        2'd0:    rsp_data = AUTH_PROTO_VER;
        2'd1:    rsp_data = hdr_b1;
        2'd2:    rsp_data = hdr_b2;
        default: rsp_data = 8'h00;
      endcase
    end else if (in_data && buf_valid) begin
      rsp_data = buf_head;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ver_q     <= '0;
      type_q    <= '0;
      slot_q    <= '0;
      off_q     <= '0;
      len_q     <= '0;
      failed    <= 1'b0;
      hdr_b1    <= '0;
      hdr_b2    <= '0;
      hdr_idx   <= '0;
      data_left <= '0;
      rd_left   <= '0;
      rd_addr   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            ver_q  <= req_in.version;
            type_q <= req_in.msg_type;
            slot_q <= req_in.slot;
            off_q  <= req_in.offset;
            len_q  <= req_in.length;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          failed    <= (chk_code != ERR_NONE);
          hdr_b1    <= (chk_code != ERR_NONE) ? MSG_ERROR : MSG_CERTIFICATE;
          hdr_b2    <= (chk_code != ERR_NONE) ? chk_code : slot_q;
          data_left <= (chk_code != ERR_NONE) ? '0 : chk_n;
          rd_left   <= (chk_code != ERR_NONE) ? '0 : chk_n;
          rd_addr   <= start_addr;
          hdr_idx   <= '0;
          state     <= ST_SEND_HDR;
        end
        ST_SEND_HDR: begin
          if (rsp_ready) begin
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) state <= (data_left != '0) ? ST_SEND_DATA : ST_FINISH;
          end
        end
        ST_SEND_DATA: begin
          if (buf_pop) begin
            data_left <= data_left - N_W'(1);
            if (data_left == N_W'(1)) state <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
      if (mem_rd) begin
        rd_addr <= rd_addr + ADDR_W'(1);
        rd_left <= rd_left - N_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cert_chain_responder.sv
// Directed bench for cert_chain_responder: vector table plus reset, backpressure and back-to-back sequences.
module tb_cert_chain_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_msg = '0;
  logic [3:0]  slot_provisioned = 4'b1101;
  logic [63:0] slot_len_flat = {16'd1024, 16'd300, 16'd100, 16'd300};
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic        rsp_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        err;

  cert_chain_responder dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_msg          (req_msg),
    .slot_provisioned (slot_provisioned),
    .slot_len_flat    (slot_len_flat),
    .mem_rd           (mem_rd),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_last         (rsp_last),
    .rsp_ready        (rsp_ready),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ver;
    logic [7:0]  typ;
    logic [7:0]  slot;
    logic [15:0] off;
    logic [15:0] len;
    logic [7:0]  e_b1;
    logic [7:0]  e_b2;
    int          e_n;
    logic [11:0] e_addr;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic bp_en = 1'b0;

  function automatic logic [7:0] mem_f(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem_f(mem_addr);
  end

  always @(posedge clk) begin
    #1;
    rsp_ready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: captures transferred bytes and watches stream stability and read gating.
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  int   m_idx = 0;
  int   m_occ = 0;
  logic m_infl = 1'b0;
  logic m_pop;
  logic pv = 1'b0;
  logic pr = 1'b1;
  logic [7:0] pd = '0;
  logic pl = 1'b0;
  int   stall_viol = 0;
  int   full_rd_viol = 0;
  int   stall_cycles = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_idx = 0; m_occ = 0; m_infl = 1'b0; pv = 1'b0; pr = 1'b1;
    end else begin
      if (pv && !pr) begin
        stall_cycles++;
        if (!rsp_valid || rsp_data !== pd || rsp_last !== pl) stall_viol++;
      end
      if (mem_rd && m_occ == 2) full_rd_viol++;
      m_pop = rsp_valid && rsp_ready && (m_idx >= 4);
      m_occ = m_occ + int'(m_infl) - int'(m_pop);
      m_infl = mem_rd;
      if (rsp_valid && rsp_ready) begin
        got_q.push_back(rsp_data);
        got_last_q.push_back(rsp_last);
        m_idx = rsp_last ? 0 : m_idx + 1;
      end
      pv = rsp_valid; pr = rsp_ready; pd = rsp_data; pl = rsp_last;
    end
  end

  task automatic append_exp(input vec_t v);
    exp_q.push_back(8'h01); exp_last_q.push_back(1'b0);
    exp_q.push_back(v.e_b1); exp_last_q.push_back(1'b0);
    exp_q.push_back(v.e_b2); exp_last_q.push_back(1'b0);
    exp_q.push_back(8'h00); exp_last_q.push_back(v.e_n == 0);
    for (int i = 0; i < v.e_n; i++) begin
      exp_q.push_back(mem_f(v.e_addr + 12'(i)));
      exp_last_q.push_back(i == v.e_n - 1);
    end
  endtask

  task automatic drive_req(input vec_t v);
    @(posedge clk); #1;
    req_msg   = {v.ver, v.typ, v.slot, 8'h00, v.off, v.len};
    req_valid = 1'b1;
  endtask

  task automatic wait_accept(input string tag, output int t);
    t = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin t = cyc; break; end
    end
    check({tag, "_accepted"}, 32'(t >= 0), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int d, output logic e);
    d = -1; e = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin d = cyc; e = err; break; end
    end
    check({tag, "_done_seen"}, 32'(d >= 0), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        check($sformatf("%s_byte%0d", tag, i), {23'd0, got_last_q[i], got_q[i]},
              {23'd0, exp_last_q[i], exp_q[i]});
        break;
      end
    end
  endtask

  // Single request with rsp_ready free-running; checks bytes, done timing, err and req_ready recovery.
  task automatic run_vec(input string tag, input vec_t v, input logic timed);
    int t, d;
    logic e;
    got_q.delete(); got_last_q.delete(); exp_q.delete(); exp_last_q.delete();
    append_exp(v);
    drive_req(v);
    wait_accept(tag, t);
    @(posedge clk); #1; req_valid = 1'b0;
    wait_done(tag, 4000, d, e);
    if (timed) check({tag, "_done_cycle"}, 32'(d - t), 32'(6 + v.e_n));
    check({tag, "_err"}, {31'd0, e}, {31'd0, v.e_b1 == 8'h7F});
    check({tag, "_ready_at_done"}, {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_ready_after_done"}, {30'd0, req_ready, busy}, 32'b10);
    compare_stream(tag);
  endtask

  vec_t vecs[13];
  vec_t va;
  vec_t vb;

  initial begin
    int t1, t2, d, early, k;
    logic e;

    vecs[0]  = '{8'h01, 8'h82, 8'd0, 16'd0,    16'd100,    8'h02, 8'h00, 100, 12'h000};
    vecs[1]  = '{8'h01, 8'h82, 8'd2, 16'd280,  16'd100,    8'h02, 8'h02, 20,  12'h918};
    vecs[2]  = '{8'h01, 8'h82, 8'd3, 16'd0,    16'h1000,   8'h02, 8'h03, 256, 12'hC00};
    vecs[3]  = '{8'h01, 8'h81, 8'd0, 16'd0,    16'd10,     8'h7F, 8'h01, 0,   12'h000};
    vecs[4]  = '{8'h01, 8'h82, 8'd1, 16'd0,    16'd10,     8'h7F, 8'h02, 0,   12'h000};
    vecs[5]  = '{8'h01, 8'h82, 8'd0, 16'd300,  16'd10,     8'h7F, 8'h03, 0,   12'h000};
    vecs[6]  = '{8'h02, 8'h82, 8'd0, 16'd0,    16'd10,     8'h7F, 8'h01, 0,   12'h000};
    vecs[7]  = '{8'h01, 8'h82, 8'd4, 16'd0,    16'd10,     8'h7F, 8'h02, 0,   12'h000};
    vecs[8]  = '{8'h01, 8'h82, 8'd0, 16'd0,    16'd0,      8'h7F, 8'h03, 0,   12'h000};
    vecs[9]  = '{8'h01, 8'h82, 8'd3, 16'd1000, 16'd100,    8'h02, 8'h03, 24,  12'hFE8};
    vecs[10] = '{8'h01, 8'h82, 8'd0, 16'd0,    16'd1,      8'h02, 8'h00, 1,   12'h000};
    vecs[11] = '{8'h01, 8'h82, 8'd2, 16'd299,  16'd5,      8'h02, 8'h02, 1,   12'h92B};
    vecs[12] = '{8'h01, 8'h81, 8'd1, 16'd0,    16'd10,     8'h7F, 8'h01, 0,   12'h000};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {25'd0, req_ready, rsp_valid, rsp_last, mem_rd, busy, done, err}, 32'b1000000);
    check("reset_data", {12'd0, mem_addr, rsp_data}, 32'd0);

    for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b1);

    // Backpressure: same 64-byte response unstalled, then with rsp_ready high ~30% of cycles.
    va = '{8'h01, 8'h82, 8'd0, 16'd10, 16'd64, 8'h02, 8'h00, 64, 12'h00A};
    run_vec("bp_free", va, 1'b1);
    stall_viol = 0; full_rd_viol = 0; stall_cycles = 0;
    bp_en = 1'b1;
    run_vec("bp_stall", va, 1'b0);
    bp_en = 1'b0;
    @(posedge clk); #2;
    check("bp_stalls_seen", 32'(stall_cycles > 0), 32'd1);
    check("bp_stable", 32'(stall_viol), 32'd0);
    check("bp_no_rd_when_full", 32'(full_rd_viol), 32'd0);

    // Reset while data byte 10 (stream index 13) is presented.
    got_q.delete(); got_last_q.delete();
    drive_req(vecs[0]);
    wait_accept("rst", t1);
    @(posedge clk); #1; req_valid = 1'b0;
    k = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (k == 13) break;
        k++;
      end
    end
    check("rst_reached_byte13", 32'(k), 32'd13);
    reset = 1'b1;
    @(negedge clk);
    check("rst_outputs", {24'd0, rsp_valid, rsp_last, mem_rd, busy, done, err, req_ready, |rsp_data},
          32'b00000010);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_no_done", {31'd0, done}, 32'd0);
    run_vec("post_rst", vecs[0], 1'b1);

    // Back-to-back: second request held valid throughout the first response.
    va = '{8'h01, 8'h82, 8'd3, 16'd0, 16'd40, 8'h02, 8'h03, 40, 12'hC00};
    vb = '{8'h01, 8'h82, 8'd0, 16'd5, 16'd12, 8'h02, 8'h00, 12, 12'h005};
    got_q.delete(); got_last_q.delete(); exp_q.delete(); exp_last_q.delete();
    append_exp(va);
    append_exp(vb);
    drive_req(va);
    wait_accept("b2b_a", t1);
    @(posedge clk); #1;
    req_msg = {vb.ver, vb.typ, vb.slot, 8'h00, vb.off, vb.len};
    early = 0; d = -1;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (done) begin d = cyc; break; end
      if (req_ready) early++;
    end
    check("b2b_a_done_cycle", 32'(d - t1), 32'(6 + va.e_n));
    check("b2b_ready_held_low", 32'(early), 32'd0);
    @(negedge clk);
    t2 = cyc;
    check("b2b_ready_after_done", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    wait_done("b2b_b", 400, d, e);
    check("b2b_b_done_cycle", 32'(d - t2), 32'(6 + vb.e_n));
    check("b2b_b_err", {31'd0, e}, 32'd0);
    compare_stream("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 200000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
